// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: digit count, hex glyph table,
// blanking constant, scan FSM states and the leading-zero mask helper.
package seg_pkg;

    localparam int N_DIGITS = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}, index = nibble value
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DWELL = 1'b1
    } seg_state_e;

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  blank;
    } seg_frame_t;

    // Bit k set when digit k and every higher digit hold zero
    // and digit k is not already blanked; digit 0 never set.
    function automatic logic [7:0] lz_mask_f(
        input logic [31:0] digits,
        input logic [7:0]  blank
    );
        logic [7:0] m;
        logic       run;
        m   = '0;
        run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            run  = run & (digits[4*k +: 4] == 4'h0);
            m[k] = run & ~blank[k];
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Producer/display bundle: digit load handshake in, scan pins out.
// master = producer side, slave = scan controller.
interface seg_scan_ctrl_if;

    logic [31:0] digits;
    logic [7:0]  dp_mask;
    logic [7:0]  blank_mask;
    logic        load_req;
    logic        load_ack;
    logic [7:0]  dig_sel;
    logic [7:0]  seg_out;
    logic        frame_done;

    modport master (
        output digits, dp_mask, blank_mask, load_req,
        input  load_ack, dig_sel, seg_out, frame_done
    );

    modport slave (
        input  digits, dp_mask, blank_mask, load_req,
        output load_ack, dig_sel, seg_out, frame_done
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low {dp,g..a} pattern.
// Ports: nibble, dp (1 = lit), blank (1 = all dark), seg.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = blank ? SEG_OFF : {~dp, HEX_SEG[nibble]};
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit seven-segment scan controller with frame-aligned shadow load.
// Ports: clk, rst_n (sync, active-high), bus (seg_scan_ctrl_if.slave).
// SEG_SCAN_LZ_SUPPRESS_EN: enables leading-zero suppression.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DWELL_CYC = 50000,
    parameter int GUARD_CYC = 500
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int MAX_CYC =
        (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
    localparam int CW =
        (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);

    seg_state_e    state, state_n;
    logic [2:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    seg_frame_t    shadow;

    logic          frame_end;
    logic          pre_end;
    logic [3:0]    nib_n;
    logic          dp_n;
    logic          blank_n;
    logic [7:0]    dec_n;
    logic [7:0]    seg_n;
    logic [7:0]    dig_n;

    logic [7:0]    dig_q;
    logic [7:0]    seg_q;
    logic          ack_q;
    logic          done_q;

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    logic [7:0]    lz_mask;
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + CW'(1);
        unique case (state)
            ST_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_n = ST_DWELL;
                    cnt_n   = '0;
                end
            end
            ST_DWELL: begin
                if (cnt == DWELL_LAST) begin
                    state_n = ST_GUARD;
                    cnt_n   = '0;
                    idx_n   = idx + 3'd1;
                end
            end
        endcase
    end

    // Frame boundary: the edge that leaves digit 7's dwell.
    assign frame_end = (state == ST_DWELL)
                     && (cnt == DWELL_LAST)
                     && (idx == 3'd7);

    // Next cycle is the last dwell cycle of digit 7: the registered
    // frame_done/load_ack are high in exactly that cycle.
    assign pre_end = (state_n == ST_DWELL)
                   && (cnt_n == DWELL_LAST)
                   && (idx_n == 3'd7);

    assign nib_n   = shadow.digits[{idx_n, 2'b00} +: 4];
    assign dp_n    = shadow.dp[idx_n];
    assign blank_n = shadow.blank[idx_n];

    seg_hex_decode u_dec (
        .nibble (nib_n),
        .dp     (dp_n),
        .blank  (blank_n),
        .seg    (dec_n)
    );

    always_comb begin
        seg_n = SEG_OFF;
        dig_n = SEG_OFF;
        if (state_n == ST_DWELL) begin
            dig_n = ~(8'd1 << idx_n);
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
            // Suppressed zero keeps only its decimal point
            seg_n = lz_mask[idx_n] ? {~dp_n, 7'h7F} : dec_n;
`else
            seg_n = dec_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state  <= ST_GUARD;
            idx    <= '0;
            cnt    <= '0;
            shadow <= '0;
            dig_q  <= SEG_OFF;
            seg_q  <= SEG_OFF;
            ack_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            dig_q  <= dig_n;
            seg_q  <= seg_n;
            done_q <= pre_end;
            ack_q  <= pre_end & bus.load_req;
            // Producer holds data until it sees the ack, so the
            // capture lands on the boundary edge itself.
            if (frame_end && ack_q) begin
                shadow <= {bus.digits, bus.dp_mask, bus.blank_mask};
            end
        end
    end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            lz_mask <= '0;
        end else if (frame_end && ack_q) begin
            lz_mask <= lz_mask_f(bus.digits, bus.blank_mask);
        end
    end
`endif

    assign bus.dig_sel    = dig_q;
    assign bus.seg_out    = seg_q;
    assign bus.load_ack   = ack_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed vector table, reset corner
// sequence, then random loads/resets against a frame-timing model.
module tb_seg_scan_ctrl;

    localparam int DW    = 4;
    localparam int GC    = 2;
    localparam int SLOT  = DW + GC;
    localparam int FRAME = 8 * SLOT;

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    localparam logic [7:0] LZ0 = 8'hFF;
`else
    localparam logic [7:0] LZ0 = 8'hC0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] dig;
        logic [7:0] seg;
        logic       fd;
        logic       ack;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .DWELL_CYC (DW),
        .GUARD_CYC (GC)
    ) dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   t      = 0;
    bit   dir_mode;
    bit   ack_seen;
    vec_t tbl [$];

    logic [3:0] m_nib [8];
    logic [7:0] m_dp;
    logic [7:0] m_blank;

    logic [6:0] hex7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%02h want=%02h",
                     name, t, act, exp);
        end
    endtask

    function automatic logic [7:0] m_seg(input int d);
        if (m_blank[d]) return 8'hFF;
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        if (d != 0) begin : lz
            bit z;
            z = 1'b1;
            for (int j = d; j < 8; j++)
                if (m_nib[j] != 4'h0) z = 1'b0;
            if (z) return m_dp[d] ? 8'h7F : 8'hFF;
        end
`endif
        return {~m_dp[d], hex7[m_nib[d]]};
    endfunction

    // Advance one clock; check this cycle's outputs against the model.
    task automatic tick();
        logic       r, q;
        int         pos, d, w;
        logic [7:0] e_dig, e_seg;
        logic       e_fd, e_ack;
        r = rst;
        q = bus.load_req;
        @(posedge clk);
        #1;
        if (r) begin
            t = 0;
            for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;
            m_dp    = 8'h00;
            m_blank = 8'h00;
            e_dig   = 8'hFF;
            e_seg   = 8'hFF;
            e_fd    = 1'b0;
            e_ack   = 1'b0;
        end else begin
            t++;
            pos   = t % FRAME;
            d     = pos / SLOT;
            w     = pos % SLOT;
            e_dig = (w >= GC) ? ~(8'd1 << d) : 8'hFF;
            e_seg = (w >= GC) ? m_seg(d) : 8'hFF;
            e_fd  = (pos == FRAME - 1);
            e_ack = e_fd && q;
        end
        chk("dig_sel", bus.dig_sel, e_dig);
        chk("seg_out", bus.seg_out, e_seg);
        chk("frame_done", {7'd0, bus.frame_done}, {7'd0, e_fd});
        chk("load_ack", {7'd0, bus.load_ack}, {7'd0, e_ack});
        if (dir_mode) begin
            foreach (tbl[i]) begin
                if (tbl[i].cyc == t) begin
                    chk("tbl_dig", bus.dig_sel, tbl[i].dig);
                    chk("tbl_seg", bus.seg_out, tbl[i].seg);
                    chk("tbl_fd", {7'd0, bus.frame_done},
                        {7'd0, tbl[i].fd});
                    chk("tbl_ack", {7'd0, bus.load_ack},
                        {7'd0, tbl[i].ack});
                end
            end
        end
        ack_seen = bus.load_ack;
        if (e_ack) begin
            for (int k = 0; k < 8; k++)
                m_nib[k] = bus.digits[4*k +: 4];
            m_dp    = bus.dp_mask;
            m_blank = bus.blank_mask;
        end
    endtask

    initial begin
        int rcnt;
        tbl.push_back('{0,   8'hFF, 8'hFF, 1'b0, 1'b0});
        tbl.push_back('{1,   8'hFF, 8'hFF, 1'b0, 1'b0});
        tbl.push_back('{2,   8'hFE, 8'hC0, 1'b0, 1'b0});
        tbl.push_back('{5,   8'hFE, 8'hC0, 1'b0, 1'b0});
        tbl.push_back('{6,   8'hFF, 8'hFF, 1'b0, 1'b0});
        tbl.push_back('{26,  8'hEF, 8'hC0, 1'b0, 1'b0});
        tbl.push_back('{46,  8'h7F, 8'hC0, 1'b0, 1'b0});
        tbl.push_back('{47,  8'h7F, 8'hC0, 1'b1, 1'b1});
        tbl.push_back('{50,  8'hFE, 8'hF9, 1'b0, 1'b0});
        tbl.push_back('{56,  8'hFD, 8'hA4, 1'b0, 1'b0});
        tbl.push_back('{74,  8'hEF, 8'h12, 1'b0, 1'b0});
        tbl.push_back('{92,  8'h7F, 8'hFF, 1'b0, 1'b0});
        tbl.push_back('{95,  8'h7F, 8'hFF, 1'b1, 1'b1});
        tbl.push_back('{98,  8'hFE, 8'h92, 1'b0, 1'b0});
        tbl.push_back('{104, 8'hFD, 8'hC0, 1'b0, 1'b0});
        tbl.push_back('{110, 8'hFB, 8'hB0, 1'b0, 1'b0});
        tbl.push_back('{116, 8'hF7, LZ0,   1'b0, 1'b0});
        tbl.push_back('{140, 8'h7F, LZ0,   1'b0, 1'b0});
        tbl.push_back('{143, 8'h7F, LZ0,   1'b1, 1'b0});

        bus.digits     = '0;
        bus.dp_mask    = '0;
        bus.blank_mask = '0;
        bus.load_req   = 1'b0;
        rst            = 1'b1;
        dir_mode       = 1'b1;
        ack_seen       = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Directed frames: mid-frame load, LZ pattern, third pending load
        while (t != 190) begin
            if (ack_seen) begin
                bus.load_req = 1'b0;
            end else if (t == 20) begin
                bus.digits     = 32'h8765_4321;
                bus.dp_mask    = 8'h10;
                bus.blank_mask = 8'h80;
                bus.load_req   = 1'b1;
            end else if (t == 60) begin
                bus.digits     = 32'h0000_0305;
                bus.dp_mask    = 8'h00;
                bus.blank_mask = 8'h00;
                bus.load_req   = 1'b1;
            end else if (t == 150) begin
                bus.digits     = 32'hFEDC_BA98;
                bus.dp_mask    = 8'hFF;
                bus.blank_mask = 8'h00;
                bus.load_req   = 1'b1;
            end
            tick();
        end

        // Reset one cycle before the frame boundary, load pending
        rst = 1'b1;
        tick();
        chk("rst46_ack", {7'd0, bus.load_ack}, 8'd0);
        chk("rst46_fd", {7'd0, bus.frame_done}, 8'd0);
        chk("rst46_dig", bus.dig_sel, 8'hFF);
        chk("rst46_seg", bus.seg_out, 8'hFF);
        tick();
        rst          = 1'b0;
        bus.load_req = 1'b0;
        tick();
        chk("restart_guard", bus.dig_sel, 8'hFF);
        tick();
        chk("restart_dig0", bus.dig_sel, 8'hFE);
        chk("restart_dropped", bus.seg_out, 8'hC0);
        dir_mode = 1'b0;

        // Random loads and occasional resets
        rcnt = 0;
        repeat (600) begin
            if (rst) begin
                rcnt--;
                if (rcnt <= 0) rst = 1'b0;
            end else if ($urandom_range(0, 249) == 0) begin
                rst          = 1'b1;
                rcnt         = $urandom_range(1, 3);
                bus.load_req = 1'b0;
            end else if (ack_seen) begin
                bus.load_req = 1'b0;
            end else if (!bus.load_req &&
                         $urandom_range(0, 19) == 0) begin
                bus.digits     = $urandom >> (4 * $urandom_range(0, 8));
                bus.dp_mask    = 8'($urandom);
                bus.blank_mask = ($urandom_range(0, 3) == 0) ?
                                 8'($urandom) : 8'h00;
                bus.load_req   = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
